// File: rtl/info_bits_extractor_if.sv
// Frame input, packed-word output stream and status flags of the info-bit extractor.
// master = extractor side, slave = frame source / word consumer side.
interface info_bits_extractor_if #(
  parameter int N = 1024,
  parameter int W = 32
);
  logic         I_frame_done;
  logic [N-1:0] I_decoded_bits;
  logic [N-1:0] I_frozen_mask;
  logic         O_busy;
  logic [W-1:0] O_data;
  logic         O_valid;
  logic         I_ready;
  logic         O_last;
  logic         O_mask_err;
  logic         O_overrun;

  modport master (
    input  I_frame_done, I_decoded_bits, I_frozen_mask, I_ready,
    output O_busy, O_data, O_valid, O_last, O_mask_err, O_overrun
  );

  modport slave (
    output I_frame_done, I_decoded_bits, I_frozen_mask, I_ready,
    input  O_busy, O_data, O_valid, O_last, O_mask_err, O_overrun
  );
endinterface

// File: rtl/info_bits_extractor.sv
// Captures a decoded frame plus frozen mask, drops frozen positions two per cycle and
// packs the remaining information bits LSB-first into W-bit words on a valid/ready stream.
module info_bits_extractor #(
  parameter int N = 1024,
  parameter int K = 512,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  info_bits_extractor_if.master bus,
  output logic [1:0]           dbg_state
);
  localparam int LW = $clog2(N);
  localparam int PW = LW + 1;
  localparam int CW = $clog2(W + 2);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FLUSH = 2'd2} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   bits_q, mask_q;
  logic [PW-1:0]  pos, pos_nx;
  logic [PW-1:0]  info_count, info_count_nx, info_sum;
  logic [PW-1:0]  last_info, cap_last;
  logic [W:0]     acc, acc_nx, appended;
  logic [CW-1:0]  cnt, cnt_nx, cnt_app;
  logic [W-1:0]   data_q, data_nx;
  logic           valid_q, valid_nx, last_q, last_nx;
  logic           mask_err, mask_err_nx, overrun;
  logic           capture, out_free;
  logic [LW-1:0]  pos_lo, pos_hi;
  logic [1:0]     n_info;

  // Highest information index of the incoming frame; lets a word be flagged last
  // the moment it completes, even when only frozen positions follow it.
  always_comb begin
    cap_last = '0;
    for (int i = 0; i < N; i++) begin
      if (!bus.I_frozen_mask[i]) cap_last = PW'(i);
    end
  end

  // Stream handshake: a word transfers on a rising clk edge where O_valid && I_ready.
  // While O_valid && !I_ready, O_data/O_last hold and O_valid stays high (only reset drops it).
  assign out_free = !valid_q || bus.I_ready;
  assign capture  = (state == IDLE) && bus.I_frame_done;
  assign pos_lo   = pos[LW-1:0];
  assign pos_hi   = pos_lo + LW'(1);
  assign n_info   = {1'b0, !mask_q[pos_lo]} + {1'b0, !mask_q[pos_hi]};

  always_comb begin
    appended = acc;
    cnt_app  = cnt;
    if (!mask_q[pos_lo]) begin
      appended[cnt_app] = bits_q[pos_lo];
      cnt_app           = cnt_app + CW'(1);
    end
    if (!mask_q[pos_hi]) begin
      appended[cnt_app] = bits_q[pos_hi];
      cnt_app           = cnt_app + CW'(1);
    end
    info_sum = info_count + PW'(n_info);
    if (info_sum > PW'(N)) info_sum = PW'(N);
  end

  always_comb begin
    state_nx      = state;
    pos_nx        = pos;
    acc_nx        = acc;
    cnt_nx        = cnt;
    info_count_nx = info_count;
    mask_err_nx   = mask_err;
    data_nx       = data_q;
    valid_nx      = valid_q;
    last_nx       = last_q;
    if (valid_q && bus.I_ready) begin
      valid_nx = 1'b0;
      last_nx  = 1'b0;
    end
    case (state)
      IDLE: begin
        if (bus.I_frame_done) begin
          pos_nx        = '0;
          acc_nx        = '0;
          cnt_nx        = '0;
          info_count_nx = '0;
          state_nx      = SCAN;
        end
      end
      SCAN: begin
        // A completed word with a still-occupied output register stalls the scan.
        if ((cnt_app < CW'(W)) || out_free) begin
          pos_nx        = pos + PW'(2);
          info_count_nx = info_sum;
          if (cnt_app >= CW'(W)) begin
            data_nx  = appended[W-1:0];
            valid_nx = 1'b1;
            acc_nx   = {{W{1'b0}}, appended[W]};
            cnt_nx   = cnt_app - CW'(W);
            last_nx  = (cnt_nx == '0) && (last_info <= pos + PW'(1));
          end else begin
            acc_nx = appended;
            cnt_nx = cnt_app;
          end
          if (pos_lo == LW'(N - 2)) begin
            mask_err_nx = (info_sum != PW'(K));
            state_nx    = (info_sum == '0) ? IDLE : FLUSH;
          end
        end
      end
      FLUSH: begin
        if (cnt != '0) begin
          if (out_free) begin
            data_nx  = acc[W-1:0];
            valid_nx = 1'b1;
            last_nx  = 1'b1;
            acc_nx   = '0;
            cnt_nx   = '0;
          end
        end else if (out_free) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bits_q     <= '0;
      mask_q     <= '0;
      pos        <= '0;
      info_count <= '0;
      last_info  <= '0;
      acc        <= '0;
      cnt        <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      mask_err   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      pos        <= pos_nx;
      info_count <= info_count_nx;
      acc        <= acc_nx;
      cnt        <= cnt_nx;
      data_q     <= data_nx;
      valid_q    <= valid_nx;
      last_q     <= last_nx;
      mask_err   <= mask_err_nx;
      if (capture) begin
        bits_q    <= bus.I_decoded_bits;
        mask_q    <= bus.I_frozen_mask;
        last_info <= cap_last;
      end
      if (bus.I_frame_done && (state != IDLE)) overrun <= 1'b1;
    end
  end

  assign bus.O_busy     = (state != IDLE);
  assign bus.O_data     = data_q;
  assign bus.O_valid    = valid_q;
  assign bus.O_last     = last_q;
  assign bus.O_mask_err = mask_err;
  assign bus.O_overrun  = overrun;
  assign dbg_state      = state;
endmodule
